db15_serial_pad: RTL



---
 rtl/db15_serial_pad.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/db15_serial_pad.sv
// Poller for the DB15 joystick adaptor: loads a 24-bit 74HC165-style chain, shifts it out
// bit by bit and presents two active-high 12-button joystick words plus presence flags.
module db15_serial_pad #(
    parameter int CLK_DIV  = 16,
    parameter int POLL_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    input  logic        JOY_DATA,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  connected,
    output logic        frame_valid
);
    localparam int PW = $clog2(POLL_DIV);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [DW-1:0] LOAD_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   raw_q, raw_d;
    logic [1:0]    sync_q;
    logic          joy_clk_q, joy_clk_d;
    logic          joy_load_q, joy_load_d;
    logic [15:0]   joy1_q, joy1_d;
    logic [15:0]   joy2_q, joy2_d;
    logic [1:0]    conn_q, conn_d;
    logic          fv_q, fv_d;
    logic          tick_s;
    logic          half_end_s;

    // Serial bit k of a stage is button 11-k; an all-zero stage means nothing is driving the chain.
    function automatic logic [11:0] decode_player(input logic [11:0] raw);
        logic [11:0] w;
        w = 12'h000;
        for (int k = 0; k < 12; k++) begin
            w[11-k] = ~raw[k];
        end
        if (raw == 12'h000) begin
            w = 12'h000;
        end else begin
            w = w;
        end
        return w;
    endfunction

    assign tick_s     = (poll_q == POLL_LAST);
    assign half_end_s = (div_q == HALF_LAST);

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            poll_q     <= '0;
            div_q      <= '0;
            bit_q      <= 5'd0;
            raw_q      <= 24'h000000;
            sync_q     <= 2'b11;
            joy_clk_q  <= 1'b1;
            joy_load_q <= 1'b1;
            joy1_q     <= 16'h0000;
            joy2_q     <= 16'h0000;
            conn_q     <= 2'b00;
            fv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_q     <= poll_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            raw_q      <= raw_d;
            sync_q     <= {sync_q[0], JOY_DATA};
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            conn_q     <= conn_d;
            fv_q       <= fv_d;
        end
    end

    // Next-state logic; a tick outside IDLE is simply lost
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_s) state_d = S_LOAD;
                    else        state_d = S_IDLE;
                end
                S_LOAD: begin
                    if (div_q == LOAD_LAST) state_d = S_SHIFT_LO;
                    else                    state_d = S_LOAD;
                end
                S_SHIFT_LO: begin
                    if (half_end_s) state_d = (bit_q == 5'd23) ? S_DONE : S_SHIFT_HI;
                    else            state_d = S_SHIFT_LO;
                end
                S_SHIFT_HI: begin
                    if (half_end_s) state_d = S_SHIFT_LO;
                    else            state_d = S_SHIFT_HI;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Poll/phase/bit counters and raw capture at the end of each low phase
    always_comb begin
        poll_d = tick_s ? '0 : poll_q + PW'(1);
        raw_d  = raw_q;
        bit_d  = bit_q;
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        if (state_q == S_LOAD) begin
            bit_d = 5'd0;
        end else if ((state_q == S_SHIFT_HI) && (state_d == S_SHIFT_LO)) begin
            bit_d = bit_q + 5'd1;
        end else begin
            bit_d = bit_q;
        end
        if (enable && (state_q == S_SHIFT_LO) && half_end_s) begin
            raw_d[bit_q] = sync_q[1];
        end else begin
            raw_d = raw_q;
        end
    end

    // Output logic: pins follow the upcoming state so they change on the same edge as the FSM
    always_comb begin
        joy_clk_d  = (state_d != S_SHIFT_LO);
        joy_load_d = (state_d != S_LOAD);
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        conn_d     = conn_q;
        fv_d       = 1'b0;
        if (!enable) begin
            joy1_d = 16'h0000;
            joy2_d = 16'h0000;
            conn_d = 2'b00;
        end else if (state_q == S_DONE) begin
            joy1_d = {4'h0, decode_player(raw_q[11:0])};
            joy2_d = {4'h0, decode_player(raw_q[23:12])};
            conn_d = {(raw_q[23:12] != 12'h000), (raw_q[11:0] != 12'h000)};
            fv_d   = 1'b1;
        end else begin
            fv_d = 1'b0;
        end
    end

    assign JOY_CLK     = joy_clk_q;
    assign JOY_LOAD    = joy_load_q;
    assign joystick1   = joy1_q;
    assign joystick2   = joy2_q;
    assign connected   = conn_q;
    assign frame_valid = fv_q;
endmodule
